// File: rtl/dmem_responder.sv
// Data-memory responder for the LSU access port: byte-lane writes and word
// reads on an internal synchronous RAM, with programmable wait states and stall.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_a_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        stall_req_o
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic capture, commit;

  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [3:0]        cap_sel;
  logic [31:0]       cap_wdata;
  logic              cap_err;

  logic [ADDR_W-1:0] c_addr;
  logic              c_we;
  logic [3:0]        c_sel;
  logic [31:0]       c_wdata;
  logic              c_err;

  logic [31:0] ram [DEPTH];
  logic [31:0] rdata_q;
  logic        in_err;
  logic        unused_a;

  assign in_err   = |mem_a_i[31:ADDR_W+2];
  assign unused_a = ^mem_a_i[1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_ce_i) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit    = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = WAIT_LOAD;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the capture edge, so the
  // live inputs are used instead of the captured copies.
  always_comb begin
    if (state == IDLE) begin
      c_addr  = mem_a_i[ADDR_W+1:2];
      c_we    = mem_we_i;
      c_sel   = mem_sel_i;
      c_wdata = mem_data_i;
      c_err   = in_err;
    end else begin
      c_addr  = cap_addr;
      c_we    = cap_we;
      c_sel   = cap_sel;
      c_wdata = cap_wdata;
      c_err   = cap_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      cap_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rdata_q <= (commit && !c_we && !c_err) ? ram[c_addr] : '0;
      if (capture) cap_err <= in_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && capture) begin
      cap_addr  <= mem_a_i[ADDR_W+1:2];
      cap_we    <= mem_we_i;
      cap_sel   <= mem_sel_i;
      cap_wdata <= mem_data_i;
    end
  end

  // RAM is never cleared; reset only suppresses a commit still in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && c_we && !c_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_sel[i]) ram[c_addr][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  assign mem_ack_o   = (state == RESP);
  assign mem_err_o   = (state == RESP) && cap_err;
  assign mem_data_o  = (state == RESP) ? rdata_q : '0;
  assign stall_req_o = !rst_i && (((state == IDLE) && mem_ce_i) || (state == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (1 and 0 wait states),
// directed scenarios plus random traffic against a word-array reference model.
module tb_dmem_responder;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce    [2];
  logic        we    [2];
  logic [31:0] a     [2];
  logic [3:0]  sel   [2];
  logic [31:0] wd    [2];
  logic [31:0] dout  [2];
  logic        ack   [2];
  logic        err   [2];
  logic        stall [2];
  bit          in_resp [2];

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] ref_mem [int];
  int total = 0;
  int bad   = 0;
  int pool [9] = '{0, 1, 2, 3, 5, 8, 'h10, 'h40, DEPTH - 1};

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_a_i(a[0]),
    .mem_sel_i(sel[0]), .mem_data_i(wd[0]), .mem_data_o(dout[0]), .mem_ack_o(ack[0]),
    .mem_err_o(err[0]), .stall_req_o(stall[0])
  );

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_a_i(a[1]),
    .mem_sel_i(sel[1]), .mem_data_i(wd[1]), .mem_data_o(dout[1]), .mem_ack_o(ack[1]),
    .mem_err_o(err[1]), .stall_req_o(stall[1])
  );

  function automatic int wait_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: memory as a word array keyed by instance and word index.
  function automatic exp_t model(input int i, input bit w, input logic [31:0] av,
                                 input logic [3:0] sv, input logic [31:0] dv);
    exp_t e;
    int key;
    logic [31:0] word;
    e.err  = (av >= 32'(4 * DEPTH));
    e.data = '0;
    if (e.err) return e;
    key = i * DEPTH + int'(av / 4);
    if (w) begin
      word = ref_mem.exists(key) ? ref_mem[key] : 'x;
      for (int b = 0; b < 4; b++)
        if (sv[b]) word[8*b +: 8] = dv[8*b +: 8];
      ref_mem[key] = word;
    end else begin
      e.data = ref_mem[key];
    end
    return e;
  endfunction

  task automatic mon(input int i);
    exp_t e;
    if (ack[i] === 1'b1) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        chk($sformatf("unexpected_ack%0d", i), 32'(ack[i]), 32'd0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("resp_data%0d", i), dout[i], e.data);
        chk($sformatf("resp_err%0d", i), 32'(err[i]), 32'(e.err));
      end
    end else begin
      chk($sformatf("idle_data%0d", i), dout[i], 32'd0);
      chk($sformatf("idle_err%0d", i), 32'(err[i]), 32'd0);
    end
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  // Called at posedge+1; holds the request until the ack cycle like the LSU.
  task automatic access(input int i, input bit w, input logic [31:0] av,
                        input logic [3:0] sv, input logic [31:0] dv);
    exp_t e;
    int k;
    e = model(i, w, av, sv, dv);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    ce[i] = 1'b1; we[i] = w; a[i] = av; sel[i] = sv; wd[i] = dv;
    if (in_resp[i]) @(posedge clk);
    #1 chk($sformatf("stall_req%0d", i), 32'(stall[i]), 32'd1);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (ack[i] !== 1'b1 && k <= wait_of(i))
        chk($sformatf("stall_wait%0d", i), 32'(stall[i]), 32'd1);
    end while (ack[i] !== 1'b1 && k < 40);
    chk($sformatf("ack_latency%0d", i), 32'(k), 32'(wait_of(i) + 1));
    chk($sformatf("stall_resp%0d", i), 32'(stall[i]), 32'd0);
    in_resp[i] = 1'b1;
  endtask

  task automatic idle(input int i, input int n);
    ce[i] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk($sformatf("stall_idle%0d", i), 32'(stall[i]), 32'd0);
    end
    in_resp[i] = 1'b0;
  endtask

  task automatic prefill(input int i);
    foreach (pool[p]) access(i, 1'b1, 32'(pool[p] * 4), 4'hF, $urandom);
  endtask

  task automatic random_traffic(input int i, input int n);
    logic [31:0] av;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 2) == 0) idle(i, $urandom_range(1, 2));
      av = 32'(pool[$urandom_range(0, 8)] * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) av = av | (32'd1 << $urandom_range(AW + 2, 31));
      access(i, 1'($urandom_range(0, 1)), av, 4'($urandom_range(0, 15)), $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ce[1] = 1'b0; we[1] = 1'b0; a[1] = '0; sel[1] = '0; wd[1] = '0;
    ce[0] = 1'b1; we[0] = 1'b1; a[0] = 32'h100; sel[0] = 4'hF; wd[0] = 32'hDEADBEEF;
    in_resp[0] = 1'b0; in_resp[1] = 1'b0;

    // Reset held two cycles with a request pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    chk("rst_data", dout[0], 32'd0);
    chk("rst_stall", 32'(stall[0]), 32'd0);
    rst = 1'b0;

    access(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    access(0, 1'b0, 32'h100, 4'h0, 32'h0);

    // Partial-lane and empty-lane writes
    access(0, 1'b1, 32'h40, 4'hF, 32'h11223344);
    access(0, 1'b1, 32'h41, 4'b0010, 32'hAAAAAAAA);
    access(0, 1'b0, 32'h40, 4'hF, 32'h0);
    access(0, 1'b1, 32'h40, 4'b0000, 32'h99999999);
    access(0, 1'b0, 32'h40, 4'h0, 32'h0);

    // Out-of-range accesses
    access(0, 1'b1, 32'h0, 4'hF, 32'h0BADF00D);
    idle(0, 1);
    access(0, 1'b1, 32'h4000, 4'hF, 32'hFFFFFFFF);
    access(0, 1'b0, 32'h0, 4'hF, 32'h0);
    access(0, 1'b0, 32'h4000, 4'hF, 32'h0);
    access(0, 1'b0, 32'h3FFC, 4'hF, 32'h0);

    // Reset during WAIT discards the write
    access(0, 1'b1, 32'h8, 4'hF, 32'h01020304);
    ce[0] = 1'b0;
    @(posedge clk); #1;
    ce[0] = 1'b1; we[0] = 1'b1; a[0] = 32'h8; sel[0] = 4'hF; wd[0] = 32'h55AA55AA;
    #1 chk("t6_stall_req", 32'(stall[0]), 32'd1);
    @(posedge clk); #1;
    chk("t6_stall_wait", 32'(stall[0]), 32'd1);
    rst = 1'b1; ce[0] = 1'b0;
    @(posedge clk); #1;
    chk("t6_no_ack", 32'(ack[0]), 32'd0);
    chk("t6_stall_rst", 32'(stall[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_no_ack_after", 32'(ack[0]), 32'd0);
    in_resp[0] = 1'b0;
    access(0, 1'b0, 32'h8, 4'hF, 32'h0);

    prefill(0);
    random_traffic(0, 80);
    idle(0, 2);

    // Zero wait states: back-to-back reads, stall 1,0,1,0
    prefill(1);
    idle(1, 1);
    access(1, 1'b0, 32'h40, 4'hF, 32'h0);
    access(1, 1'b0, 32'h100, 4'hF, 32'h0);
    access(1, 1'b1, 32'h10004, 4'hF, 32'h12345678);
    random_traffic(1, 80);
    idle(1, 3);

    chk("sb_empty0", 32'(q0.size()), 32'd0);
    chk("sb_empty1", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
